// File: rtl/multicycle_core.sv
// Multi-cycle 16-bit-instruction core. The FSM steps each instruction through FETCH/DECODE/EXEC/(MEM)/WB,
// with req/ack handshakes on separate instruction and data ports.
module multicycle_core #(
  parameter int WIDTH  = 16,
  parameter int ADDR_W = 16
) (
  input  logic              CLK,
  input  logic              RST,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [15:0]       imem_rdata,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [ADDR_W-1:0] dmem_addr,
  output logic [WIDTH-1:0]  dmem_wdata,
  input  logic              dmem_ack,
  input  logic [WIDTH-1:0]  dmem_rdata,
  output logic              halted,
  output logic [ADDR_W-1:0] pc_dbg,
  output logic [2:0]        state_dbg
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5
  } state_t;

  localparam logic [3:0] OP_ADD  = 4'h1;
  localparam logic [3:0] OP_SUB  = 4'h2;
  localparam logic [3:0] OP_AND  = 4'h3;
  localparam logic [3:0] OP_OR   = 4'h4;
  localparam logic [3:0] OP_XOR  = 4'h5;
  localparam logic [3:0] OP_ADDI = 4'h6;
  localparam logic [3:0] OP_LI   = 4'h7;
  localparam logic [3:0] OP_LD   = 4'h8;
  localparam logic [3:0] OP_ST   = 4'h9;
  localparam logic [3:0] OP_BNZ  = 4'hA;
  localparam logic [3:0] OP_JAL  = 4'hB;
  localparam logic [3:0] OP_HALT = 4'hF;

  state_t             r_state;
  state_t             w_next;
  logic [ADDR_W-1:0]  r_pc;
  logic [ADDR_W-1:0]  r_npc;
  logic [15:0]        r_ir;
  logic [WIDTH-1:0]   r_a;
  logic [WIDTH-1:0]   r_b;
  logic [WIDTH-1:0]   r_aux;
  logic [WIDTH-1:0]   r_regs [16];

  logic [3:0]         w_op;
  logic [3:0]         w_ra;
  logic [3:0]         w_rb;
  logic [7:0]         w_imm;
  logic [WIDTH-1:0]   w_sext;
  logic [WIDTH-1:0]   w_zext;
  logic [ADDR_W-1:0]  w_pc1;
  logic [WIDTH-1:0]   w_pc1_x;
  logic [WIDTH-1:0]   w_br_sum;
  logic [WIDTH-1:0]   w_result;
  logic [ADDR_W-1:0]  w_npc;
  logic               w_wen;

  assign w_op  = r_ir[15:12];
  assign w_ra  = r_ir[11:8];
  assign w_rb  = r_ir[7:4];
  assign w_imm = r_ir[7:0];
  assign w_pc1 = r_pc + ADDR_W'(1);

  always_comb begin
    w_sext        = {WIDTH{w_imm[7]}};
    w_sext[7:0]   = w_imm;
    w_zext        = '0;
    w_zext[7:0]   = w_imm;
    w_pc1_x       = '0;
    w_pc1_x[ADDR_W-1:0] = w_pc1;
  end

  // Branch target is formed at data width, then truncated so it wraps mod 2^ADDR_W.
  assign w_br_sum = w_pc1_x + w_sext;

  always_comb begin
    w_result = r_a;
    w_npc    = w_pc1;
    unique case (w_op)
      OP_ADD:       w_result = r_a + r_b;
      OP_SUB:       w_result = r_a - r_b;
      OP_AND:       w_result = r_a & r_b;
      OP_OR:        w_result = r_a | r_b;
      OP_XOR:       w_result = r_a ^ r_b;
      OP_ADDI:      w_result = r_a + w_sext;
      OP_LI:        w_result = w_zext;
      OP_LD, OP_ST: w_result = r_b;
      OP_BNZ:       if (r_a != '0) w_npc = w_br_sum[ADDR_W-1:0];
      OP_JAL: begin
        w_result = w_pc1_x;
        w_npc    = r_b[ADDR_W-1:0];
      end
      default:      w_result = r_a;
    endcase
  end

  always_comb begin
    unique case (w_op)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR,
      OP_ADDI, OP_LI, OP_LD, OP_JAL: w_wen = 1'b1;
      default:                       w_wen = 1'b0;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) r_state <= S_FETCH;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next   = r_state;
    imem_req = 1'b0;
    dmem_req = 1'b0;
    unique case (r_state)
      S_FETCH: begin
        imem_req = 1'b1;
        if (imem_ack) w_next = S_DECODE;
      end
      S_DECODE: w_next = S_EXEC;
      S_EXEC: begin
        if (w_op == OP_LD || w_op == OP_ST) w_next = S_MEM;
        else if (w_op == OP_HALT)           w_next = S_HALT;
        else                                w_next = S_WB;
      end
      S_MEM: begin
        dmem_req = 1'b1;
        if (dmem_ack) w_next = S_WB;
      end
      S_WB:    w_next = S_FETCH;
      S_HALT:  w_next = S_HALT;
      default: w_next = S_FETCH;
    endcase
    // State is already FETCH while RST is held; keep requests quiet until release.
    if (RST) begin
      imem_req = 1'b0;
      dmem_req = 1'b0;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_pc  <= '0;
      r_npc <= '0;
      r_ir  <= '0;
      r_a   <= '0;
      r_b   <= '0;
      r_aux <= '0;
      for (int unsigned i = 0; i < 16; i++) r_regs[i] <= '0;
    end else begin
      unique case (r_state)
        S_FETCH:  if (imem_ack) r_ir <= imem_rdata;
        S_DECODE: begin
          r_a <= (w_ra == 4'd0) ? '0 : r_regs[w_ra];
          r_b <= (w_rb == 4'd0) ? '0 : r_regs[w_rb];
        end
        S_EXEC: begin
          r_aux <= w_result;
          r_npc <= w_npc;
        end
        S_MEM:    if (dmem_ack && w_op == OP_LD) r_aux <= dmem_rdata;
        S_WB: begin
          if (w_wen && w_ra != 4'd0) r_regs[w_ra] <= r_aux;
          r_pc <= r_npc;
        end
        default: ;
      endcase
    end
  end

  assign imem_addr  = r_pc;
  assign dmem_we    = (w_op == OP_ST);
  assign dmem_addr  = r_aux[ADDR_W-1:0];
  assign dmem_wdata = r_a;
  assign halted     = (r_state == S_HALT);
  assign pc_dbg     = r_pc;
  assign state_dbg  = r_state;

endmodule

// File: tb/tb_multicycle_core.sv
// Bench for multicycle_core: a memory responder with programmable wait states,
// a store scoreboard, an ALU vector table and hand-written multi-cycle sequences.
module tb_multicycle_core;
  localparam int WIDTH  = 16;
  localparam int ADDR_W = 16;

  logic              CLK = 1'b0;
  logic              RST = 1'b1;
  logic              imem_req;
  logic [ADDR_W-1:0] imem_addr;
  logic              imem_ack;
  logic [15:0]       imem_rdata;
  logic              dmem_req;
  logic              dmem_we;
  logic [ADDR_W-1:0] dmem_addr;
  logic [WIDTH-1:0]  dmem_wdata;
  logic              dmem_ack;
  logic [WIDTH-1:0]  dmem_rdata;
  logic              halted;
  logic [ADDR_W-1:0] pc_dbg;
  logic [2:0]        state_dbg;

  multicycle_core #(.WIDTH(WIDTH), .ADDR_W(ADDR_W)) dut (
    .CLK(CLK), .RST(RST),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
    .halted(halted), .pc_dbg(pc_dbg), .state_dbg(state_dbg)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [WIDTH-1:0]  data;
  } st_t;

  typedef struct {
    logic [3:0]  op;
    logic [3:0]  dst;
    logic [7:0]  imm;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] exp;
    string       name;
  } vec_t;

  int          n_checks = 0;
  int          n_errors = 0;
  logic [15:0] imem [256];
  logic [15:0] dmem [256];
  int          iwait = 0;
  int          dwait = 0;
  st_t         sb [$];
  int          acc_len [$];
  bit          acc_stable [$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Memory responder: acks after iwait/dwait cycles of req, tracks data-port stability.
  initial begin
    int                icnt;
    int                dcnt;
    int                dlen;
    logic [ADDR_W-1:0] a0;
    logic [WIDTH-1:0]  w0;
    logic              we0;
    bit                stable;
    st_t               e;
    imem_ack = 1'b0; dmem_ack = 1'b0; imem_rdata = '0; dmem_rdata = '0;
    icnt = 0; dcnt = 0; dlen = 0; stable = 1'b1; a0 = '0; w0 = '0; we0 = 1'b0;
    forever begin
      @(negedge CLK);
      imem_ack = 1'b0;
      dmem_ack = 1'b0;
      if (imem_req) begin
        if (icnt >= iwait) begin
          imem_ack   = 1'b1;
          imem_rdata = imem[imem_addr[7:0]];
          icnt = 0;
        end else icnt++;
      end else icnt = 0;
      if (dmem_req) begin
        if (dlen == 0) begin
          a0 = dmem_addr; w0 = dmem_wdata; we0 = dmem_we; stable = 1'b1;
        end else if (dmem_addr !== a0 || dmem_wdata !== w0 || dmem_we !== we0) begin
          stable = 1'b0;
        end
        dlen++;
        if (dcnt >= dwait) begin
          dmem_ack = 1'b1;
          dcnt = 0;
          if (dmem_we) begin
            dmem[dmem_addr[7:0]] = dmem_wdata;
            if (sb.size() == 0) begin
              n_checks++; n_errors++;
              $display("FAIL unexpected_store: got addr 0x%0h data 0x%0h expected no store", dmem_addr, dmem_wdata);
            end else begin
              e = sb.pop_front();
              chk("store_addr", 32'(dmem_addr), 32'(e.addr));
              chk("store_data", 32'(dmem_wdata), 32'(e.data));
            end
          end else begin
            dmem_rdata = dmem[dmem_addr[7:0]];
          end
          acc_len.push_back(dlen);
          acc_stable.push_back(stable);
          dlen = 0;
        end else dcnt++;
      end else begin
        dcnt = 0;
        dlen = 0;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "global timeout");
  end

  task automatic clear_imem();
    for (int i = 0; i < 256; i++) imem[i] = 16'hF000;
  endtask

  task automatic push_store(input logic [ADDR_W-1:0] addr, input logic [WIDTH-1:0] data);
    st_t e;
    e.addr = addr;
    e.data = data;
    sb.push_back(e);
  endtask

  task automatic do_reset();
    RST = 1'b1;
    repeat (2) @(posedge CLK);
    #1;
    chk("rst_pc", 32'(pc_dbg), 32'd0);
    chk("rst_state", 32'(state_dbg), 32'd0);
    chk("rst_halted", 32'(halted), 32'd0);
    chk("rst_imem_req", 32'(imem_req), 32'd0);
    chk("rst_dmem_req", 32'(dmem_req), 32'd0);
    RST = 1'b0;
    #1;
    chk("first_imem_req", 32'(imem_req), 32'd1);
  endtask

  task automatic run_to_halt(input string name, input int limit, output int cycles);
    cycles = 0;
    while (1) begin
      @(posedge CLK);
      #1;
      cycles++;
      if (halted) break;
      if (cycles >= limit) begin
        n_checks++; n_errors++;
        $display("FAIL %s_halt_timeout: got no halt after %0d cycles expected halt", name, cycles);
        break;
      end
    end
  endtask

  initial begin
    vec_t vecs [13];
    int   cyc;
    int   req_cnt;
    bit   seen;

    vecs[0]  = '{4'h1, 4'd1, 8'h00, 16'h1234, 16'h0F0F, 16'h2143, "add"};
    vecs[1]  = '{4'h1, 4'd1, 8'h00, 16'hFFFF, 16'h0002, 16'h0001, "add_wrap"};
    vecs[2]  = '{4'h2, 4'd1, 8'h00, 16'h0003, 16'h0005, 16'hFFFE, "sub_under"};
    vecs[3]  = '{4'h3, 4'd1, 8'h00, 16'hF0F0, 16'h3C3C, 16'h3030, "and"};
    vecs[4]  = '{4'h4, 4'd1, 8'h00, 16'hF000, 16'h000F, 16'hF00F, "or"};
    vecs[5]  = '{4'h5, 4'd1, 8'h00, 16'hAAAA, 16'hFFFF, 16'h5555, "xor"};
    vecs[6]  = '{4'h6, 4'd1, 8'h80, 16'h0010, 16'h0000, 16'hFF90, "addi_neg"};
    vecs[7]  = '{4'h6, 4'd1, 8'h7F, 16'h1234, 16'h0000, 16'h12B3, "addi_pos"};
    vecs[8]  = '{4'h7, 4'd1, 8'hA5, 16'hFFFF, 16'h0000, 16'h00A5, "li_zext"};
    vecs[9]  = '{4'h0, 4'd1, 8'h00, 16'h4321, 16'h1111, 16'h4321, "nop"};
    vecs[10] = '{4'hC, 4'd1, 8'h00, 16'h7777, 16'h1111, 16'h7777, "rsvd_c"};
    vecs[11] = '{4'hE, 4'd1, 8'h00, 16'h1111, 16'h2222, 16'h1111, "rsvd_e"};
    vecs[12] = '{4'h1, 4'd0, 8'h00, 16'h5A5A, 16'h0101, 16'h0000, "add_r0"};

    for (int i = 0; i < 256; i++) dmem[i] = '0;

    // T2: ALU sequence, 4 cycles per non-memory instruction.
    clear_imem();
    imem[0] = 16'h7105; imem[1] = 16'h7203; imem[2] = 16'h2120; imem[3] = 16'h1010;
    imem[4] = 16'h7360; imem[5] = 16'h9130; imem[6] = 16'h7461; imem[7] = 16'h9040;
    push_store(16'h0060, 16'h0002);
    push_store(16'h0061, 16'h0000);
    do_reset();
    run_to_halt("t2", 200, cyc);
    chk("t2_cycles", 32'(cyc), 32'd37);
    chk("t2_sb_empty", 32'(sb.size()), 32'd0);

    // Vector table: operands loaded from memory, result stored to 0x50.
    for (int v = 0; v < 13; v++) begin
      clear_imem();
      dmem[8'h40] = vecs[v].a;
      dmem[8'h41] = vecs[v].b;
      imem[0] = 16'h7240; imem[1] = 16'h8120; imem[2] = 16'h7241; imem[3] = 16'h8320;
      if (vecs[v].op == 4'h6 || vecs[v].op == 4'h7) imem[4] = {vecs[v].op, vecs[v].dst, vecs[v].imm};
      else                                          imem[4] = {vecs[v].op, vecs[v].dst, 4'd3, 4'd0};
      imem[5] = 16'h7250;
      imem[6] = {4'h9, vecs[v].dst, 4'h2, 4'h0};
      push_store(16'h0050, vecs[v].exp);
      do_reset();
      run_to_halt(vecs[v].name, 200, cyc);
      chk({vecs[v].name, "_cycles"}, 32'(cyc), 32'd34);
      chk({vecs[v].name, "_sb_empty"}, 32'(sb.size()), 32'd0);
    end

    // T3: three data wait states on every access.
    clear_imem();
    dmem[8'h42] = 16'h1234;
    imem[0] = 16'h7242; imem[1] = 16'h8120; imem[2] = 16'h7210; imem[3] = 16'h9120;
    imem[4] = 16'h8320; imem[5] = 16'h7411; imem[6] = 16'h9340;
    push_store(16'h0010, 16'h1234);
    push_store(16'h0011, 16'h1234);
    dwait = 3;
    acc_len.delete();
    acc_stable.delete();
    do_reset();
    run_to_halt("t3", 300, cyc);
    chk("t3_cycles", 32'(cyc), 32'd47);
    chk("t3_sb_empty", 32'(sb.size()), 32'd0);
    chk("t3_acc_count", 32'(acc_len.size()), 32'd4);
    for (int i = 0; i < acc_len.size(); i++) begin
      chk($sformatf("t3_acc%0d_len", i), 32'(acc_len[i]), 32'd4);
      chk($sformatf("t3_acc%0d_stable", i), 32'(acc_stable[i]), 32'd1);
    end
    dwait = 0;

    // T4: countdown loop with one fetch wait state.
    clear_imem();
    imem[0] = 16'h7103; imem[1] = 16'h61FF; imem[2] = 16'hA1FE;
    imem[3] = 16'h7270; imem[4] = 16'h9120;
    push_store(16'h0070, 16'h0000);
    iwait = 1;
    do_reset();
    run_to_halt("t4", 300, cyc);
    chk("t4_cycles", 32'(cyc), 32'd50);
    chk("t4_halt_pc", 32'(pc_dbg), 32'd5);
    chk("t4_sb_empty", 32'(sb.size()), 32'd0);
    iwait = 0;

    // T5: JAL with distinct and identical ra/rb, then HALT stays quiet.
    clear_imem();
    imem[0] = 16'h7420;
    for (int i = 1; i < 7; i++) imem[i] = 16'h0000;
    imem[7]     = 16'hB540;
    imem[8'h20] = 16'h7671; imem[8'h21] = 16'h9560;
    imem[8'h22] = 16'h7730; imem[8'h23] = 16'hB770;
    imem[8'h30] = 16'h7672; imem[8'h31] = 16'h9760;
    push_store(16'h0071, 16'h0008);
    push_store(16'h0072, 16'h0024);
    do_reset();
    run_to_halt("t5", 300, cyc);
    chk("t5_cycles", 32'(cyc), 32'd61);
    chk("t5_halt_pc", 32'(pc_dbg), 32'h32);
    chk("t5_sb_empty", 32'(sb.size()), 32'd0);
    req_cnt = 0;
    repeat (20) begin
      @(posedge CLK);
      #1;
      if (imem_req) req_cnt++;
    end
    chk("t5_halted_hold", 32'(halted), 32'd1);
    chk("t5_no_req_in_halt", 32'(req_cnt), 32'd0);

    // T1: reset clears registers left non-zero by T5.
    clear_imem();
    imem[0] = 16'h7F74; imem[1] = 16'h95F0; imem[2] = 16'h97F0;
    imem[3] = 16'h94F0; imem[4] = 16'h91F0;
    for (int i = 0; i < 4; i++) push_store(16'h0074, 16'h0000);
    do_reset();
    run_to_halt("t1", 200, cyc);
    chk("t1_sb_empty", 32'(sb.size()), 32'd0);

    // T6: reset while a load is stalled in MEM.
    clear_imem();
    dmem[8'h43] = 16'hBEEF;
    imem[0] = 16'h7155; imem[1] = 16'h7243; imem[2] = 16'h8120;
    dwait = 1000;
    do_reset();
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(posedge CLK);
      #1;
      if (dmem_req) seen = 1'b1;
    end
    chk("t6_reached_mem", 32'(seen), 32'd1);
    repeat (3) @(posedge CLK);
    #1;
    RST = 1'b1;
    @(posedge CLK);
    #1;
    chk("t6_dmem_req_drop", 32'(dmem_req), 32'd0);
    chk("t6_pc", 32'(pc_dbg), 32'd0);
    chk("t6_state", 32'(state_dbg), 32'd0);
    dwait = 0;
    clear_imem();
    imem[0] = 16'h7275; imem[1] = 16'h9120;
    push_store(16'h0075, 16'h0000);
    do_reset();
    run_to_halt("t6", 200, cyc);
    chk("t6_sb_empty", 32'(sb.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
